// File: rtl/mode_ctrl.sv
// rtl/mode_ctrl.sv - front-panel mode controller: button decode, inc auto-repeat, blink, edit timeout
module mode_ctrl #(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int TIMEOUT_S     = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn_n,
  input  logic       next_btn_n,
  input  logic       inc_btn_n,
  input  logic       tick_1hz,
  output logic [3:0] state,
  output logic       down_btn,
  output logic       blink,
  output logic       edit_active
);

  typedef enum logic [3:0] {
    TIME_DISP  = 4'd0,
    DATE_DISP  = 4'd1,
    TE_SEC     = 4'd2,
    TE_MIN     = 4'd3,
    TE_HOUR    = 4'd4,
    TE_DAY     = 4'd5,
    TE_MON     = 4'd6,
    TE_YEAR    = 4'd7,
    ALARM_DISP = 4'd8,
    AE_SEC     = 4'd9,
    AE_MIN     = 4'd10,
    AE_HOUR    = 4'd11,
    TIMER_DISP = 4'd12,
    TM_SEC     = 4'd13,
    TM_MIN     = 4'd14,
    TM_HOUR    = 4'd15
  } mode_e;

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT_S + 1);

  // Mode-button destination: display ring, or back to the owning display from an edit field.
  function automatic mode_e mode_exit(input mode_e s);
    case (s)
      TIME_DISP:  mode_exit = DATE_DISP;
      DATE_DISP:  mode_exit = ALARM_DISP;
      ALARM_DISP: mode_exit = TIMER_DISP;
      TIMER_DISP: mode_exit = TIME_DISP;
      TE_SEC, TE_MIN, TE_HOUR, TE_DAY, TE_MON, TE_YEAR: mode_exit = TIME_DISP;
      AE_SEC, AE_MIN, AE_HOUR: mode_exit = ALARM_DISP;
      default:    mode_exit = TIMER_DISP;
    endcase
  endfunction

  // Next-button destination: enter the first edit field, or advance cyclically within a group.
  function automatic mode_e next_field(input mode_e s);
    case (s)
      TIME_DISP, DATE_DISP, TE_YEAR: next_field = TE_SEC;
      TE_SEC:                        next_field = TE_MIN;
      TE_MIN:                        next_field = TE_HOUR;
      TE_HOUR:                       next_field = TE_DAY;
      TE_DAY:                        next_field = TE_MON;
      TE_MON:                        next_field = TE_YEAR;
      ALARM_DISP, AE_HOUR:           next_field = AE_SEC;
      AE_SEC:                        next_field = AE_MIN;
      AE_MIN:                        next_field = AE_HOUR;
      TM_SEC:                        next_field = TM_MIN;
      TM_MIN:                        next_field = TM_HOUR;
      default:                       next_field = TM_SEC;
    endcase
  endfunction

  function automatic logic is_edit(input mode_e s);
    is_edit = !(s == TIME_DISP || s == DATE_DISP || s == ALARM_DISP || s == TIMER_DISP);
  endfunction

  mode_e            cur, nxt;
  logic [2:0]       btn_s1, btn_s2, btn_prev;
  logic [1:0]       warm;
  logic [2:0]       fall;
  logic             mode_press, next_press, inc_press, inc_held, any_press;
  logic             changed;
  logic             down_nxt, blink_nxt;
  logic             rpt_on, rpt_on_nxt, rpt_first, rpt_first_nxt;
  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nxt, rpt_limit;
  logic [TO_W-1:0]  to_cnt, to_nxt;

  // Two-flop synchronizers plus a delayed copy for falling-edge detection; bit order {mode, next, inc}.
  // Right after reset the chain holds reset values rather than pin samples, so edge detection
  // waits until three real samples have shifted in; a button held through reset is never a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1   <= 3'b111;
      btn_s2   <= 3'b111;
      btn_prev <= 3'b111;
      warm     <= 2'd0;
    end else begin
      btn_s1   <= {mode_btn_n, next_btn_n, inc_btn_n};
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  assign fall       = (warm == 2'd3) ? (btn_prev & ~btn_s2) : 3'b000;
  assign mode_press = fall[2];
  assign next_press = fall[1];
  assign inc_press  = fall[0];
  assign inc_held   = ~btn_s2[0];
  assign any_press  = |fall;
  assign rpt_limit  = rpt_first ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD);

  // Next state, timeout counter, blink and auto-repeat; any state change clears all per-field activity.
  always_comb begin
    nxt           = cur;
    to_nxt        = to_cnt;
    blink_nxt     = blink;
    down_nxt      = 1'b1;
    rpt_on_nxt    = rpt_on;
    rpt_first_nxt = rpt_first;
    rpt_cnt_nxt   = rpt_cnt;

    if (mode_press) begin
      nxt = mode_exit(cur);
    end else if (next_press) begin
      nxt = next_field(cur);
    end else if (!any_press && tick_1hz && is_edit(cur) && to_cnt >= TO_W'(TIMEOUT_S - 1)) begin
      nxt = mode_exit(cur);
    end
    changed = (nxt != cur);

    if (!is_edit(cur) || any_press || changed) begin
      to_nxt = '0;
    end else if (tick_1hz && to_cnt != TO_W'(TIMEOUT_S)) begin
      to_nxt = to_cnt + TO_W'(1);
    end

    if (changed || !is_edit(cur)) begin
      blink_nxt = 1'b0;
    end else if (tick_1hz) begin
      blink_nxt = ~blink;
    end

    if (changed) begin
      rpt_on_nxt  = 1'b0;
      rpt_cnt_nxt = '0;
    end else if (inc_press && is_edit(cur)) begin
      down_nxt      = 1'b0;
      rpt_on_nxt    = 1'b1;
      rpt_first_nxt = 1'b1;
      rpt_cnt_nxt   = RPT_W'(1);
    end else if (rpt_on) begin
      if (!inc_held) begin
        rpt_on_nxt  = 1'b0;
        rpt_cnt_nxt = '0;
      end else if (rpt_cnt == rpt_limit) begin
        down_nxt      = 1'b0;
        rpt_first_nxt = 1'b0;
        rpt_cnt_nxt   = RPT_W'(1);
      end else begin
        rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= TIME_DISP;
      down_btn  <= 1'b1;
      blink     <= 1'b0;
      to_cnt    <= '0;
      rpt_on    <= 1'b0;
      rpt_first <= 1'b0;
      rpt_cnt   <= '0;
    end else begin
      cur       <= nxt;
      down_btn  <= down_nxt;
      blink     <= blink_nxt;
      to_cnt    <= to_nxt;
      rpt_on    <= rpt_on_nxt;
      rpt_first <= rpt_first_nxt;
      rpt_cnt   <= rpt_cnt_nxt;
    end
  end

  assign state       = cur;
  assign edit_active = is_edit(cur);

endmodule
